uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Byte-stream UART transmitter that sits directly downstream of the Renode-facing UART requester: it accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serializes each one as an 8N1 frame on `tx_o`. It replaces the requester's combinational RX-to-TX loopback with a real, cycle-accurate serial line. It can be driven by a co-simulated peripheral model or by RTL.

## Interface
- `ClkDiv`, 16: clock cycles per serial bit; legal range ≥ 1.
- `FifoDepth`, 8: byte FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high, sampled on the rising edge of `clk`.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept a byte; equals `!full`.
- `tx_o`  out  1  serial line, registered, idle high.
- `busy_o`  out  1  FSM not in IDLE, or FIFO non-empty.
- `level_o`  out  $clog2(FifoDepth)+1  current FIFO occupancy, 0..FifoDepth.

## Operation
- Push: a byte is written on any edge where `valid_i && ready_o`. Bytes offered while `ready_o` is low are not taken, and the upstream must hold them.
- FIFO: circular buffer with read/write pointers of width $clog2(FifoDepth) that wrap modulo FifoDepth. A separate occupancy counter drives full/empty.
- FIFO ordering: strict FIFO with no data loss.
- Simultaneous push and pop is allowed when the FIFO is not full, and leaves `level_o` unchanged.
- `ready_o` is computed from the registered full flag. A pop in the same cycle does not make room for a push while the FIFO is full.
- FSM states: IDLE, START, DATA, STOP.
- Bit timer: a down-counter loaded with ClkDiv-1 on each state or bit entry. A bit ends on the cycle the counter reads 0.
- IDLE: `tx_o`=1. If the FIFO is non-empty, pop the head into the shift register, load the timer, and go to START.
- START: `tx_o`=0 for ClkDiv cycles, then go to DATA with bit index 0.
- DATA: `tx_o`=shift[0], sent LSB first. At each bit end, shift right and increment the index. After bit index 7 ends, go to STOP.
- STOP: `tx_o`=1 for ClkDiv cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Frame length: exactly 10·ClkDiv cycles.
- With ClkDiv=1 every state lasts one cycle, and the timer stays at 0.
- Reset, at any time including mid-frame:
  - FIFO is flushed and `level_o`=0.
  - FSM goes to IDLE, the timer and bit index clear, and `tx_o`=1.
  - The partial frame is dropped, with no stop bit appended.
- Reset output values: `tx_o`=1, `ready_o`=1, `busy_o`=0, `level_o`=0.

## Timing
- Push-to-line latency, with the FIFO empty and the FSM in IDLE:
  - Byte accepted at edge k gives `level_o`=1 after k.
  - FSM pops at edge k+1.
  - `tx_o` falls after edge k+2. This is 2 cycles from accept to start bit.
- Back-to-back bytes: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Sustained throughput: one byte per 10·ClkDiv cycles.
- `level_o` and `ready_o` update the cycle after a push or pop edge.
- `busy_o` is combinational from registered state.

## Test plan
- Single-byte frame:
  - Stimulus: reset, then ClkDiv=4, push 0x62 once.
  - Required: `tx_o` low 2 cycles after accept for 4 cycles. Data bits follow as 0,1,0,0,0,1,1,0, with 4 cycles each. Then high for 4 cycles. Then IDLE with `busy_o`=0 at 40+2 cycles.
- Back-to-back frames:
  - Stimulus: push 0x55 then 0xAA on consecutive cycles, with ClkDiv=2.
  - Required: two 20-cycle frames with no idle cycle between them, and the line reads 0x55 then 0xAA.
- FIFO full and wrap-around:
  - Stimulus: FifoDepth=8, push 9 bytes 0x00..0x08 while holding `valid_i`, with ClkDiv=4.
  - Required: `ready_o` drops once `level_o`=8. Byte 0x08 is accepted only after the first pop, with no simultaneous push-at-full. All 9 bytes appear on the line in order. Pointers wrap cleanly.
- ClkDiv=1 boundary:
  - Stimulus: push 0xFF and 0x00 with ClkDiv=1.
  - Required: each frame lasts 10 cycles. 0xFF gives 0,1×8,1. 0x00 gives 0,0×8,1.
- Reset mid-frame:
  - Stimulus: push 3 bytes, assert `rst` for 1 cycle during DATA bit 3 of the first frame.
  - Required: after the edge, `tx_o`=1, `level_o`=0, `busy_o`=0, `ready_o`=1. No further frames are sent.
  - Follow-up: a subsequent push of 0x31 is serialized normally.
- Simultaneous push and pop:
  - Stimulus: with `level_o`=3, push on the same edge the STOP state pops.
  - Required: `level_o` stays 3, and frame order is preserved.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Byte-stream 8N1 UART transmitter. Bytes arrive on a valid/ready handshake,
// are queued in a small circular FIFO, and are shifted out LSB first on a
// registered serial line. Frames are packed back to back whenever the FIFO
// still holds data at the end of a stop bit.
//
// Parameters:
//   ClkDiv     clock cycles per serial bit (>= 1)
//   FifoDepth  number of byte FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk      in   single clock, rising-edge
//   rst      in   synchronous active-high reset
//   data_i   in   byte to transmit
//   valid_i  in   data_i is valid
//   ready_o  out  FIFO can accept a byte (not full)
//   tx_o     out  registered serial line, idle high
//   busy_o   out  FSM active or FIFO non-empty
//   level_o  out  FIFO occupancy, 0..FifoDepth
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int ClkDiv    = 16,
    parameter int FifoDepth = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       tx_o,
    output logic                       busy_o,
    output logic [$clog2(FifoDepth):0] level_o
);

    localparam int PtrW   = $clog2(FifoDepth);
    // A one-cycle bit still needs a 1-bit timer so the vector is never empty.
    localparam int TimerW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(ClkDiv - 1);
    localparam logic [PtrW:0]     FullCount = (PtrW + 1)'(FifoDepth);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    // Serializer state
    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic push;
    logic pop;
    logic fifo_empty;
    logic timer_end;

    assign fifo_empty = (count_q == '0);
    // Ready comes only from registered occupancy, so a pop on a full FIFO
    // does not open a slot until the following cycle.
    assign ready_o    = (count_q != FullCount);
    assign push       = valid_i && ready_o;
    assign timer_end  = (timer_q == '0);

    assign tx_o    = tx_q;
    assign level_o = count_q;
    assign busy_o  = (state_q != IDLE) || !fifo_empty;

    // FIFO payload write; stale entries are harmless because reset clears the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame sequencer: the timer counts down from TimerLoad and each state or
    // bit ends on the cycle it reads zero.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    timer_d = TimerLoad;
                    state_d = START;
                end
            end
            START: begin
                if (timer_end) begin
                    bit_idx_d = '0;
                    timer_d   = TimerLoad;
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            DATA: begin
                if (timer_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    timer_d   = TimerLoad;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            STOP: begin
                if (timer_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        timer_d = TimerLoad;
                        state_d = START;
                    end else begin
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is registered from the current state, so it trails the FSM by
    // one cycle; every bit still lasts exactly ClkDiv cycles.
    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule
